// File: rtl/acc_dump_pkg.sv
// acc_dump_pkg: shared fixed-point formats and saturation helpers
package acc_dump_pkg;
    localparam int NB_XI_D  = 9;
    localparam int NBF_XI_D = 7;
    localparam int NB_XO_D  = 17;
    localparam int NBF_XO_D = 10;
    localparam int N_ACC_D  = 16;

    function automatic int fx_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic longint fx_max(input int nb);
        return (longint'(1) <<< (nb - 1)) - longint'(1);
    endfunction

    function automatic longint fx_min(input int nb);
        return -(longint'(1) <<< (nb - 1));
    endfunction

    localparam longint SAT_MAX_XO = fx_max(NB_XO_D);
    localparam longint SAT_MIN_XO = fx_min(NB_XO_D);
endpackage

// File: rtl/acc_dump_fx_widen.sv
// fx_widen: exact sign-extend and align of S(NB_XI,NBF_XI) into S(NB_ACC,NBF_XO)
module fx_widen
    import acc_dump_pkg::*;
#(
    parameter int NB_XI  = NB_XI_D,
    parameter int NBF_XI = NBF_XI_D,
    parameter int NB_ACC = NB_XO_D + 4,
    parameter int NBF_XO = NBF_XO_D
) (
    input  logic [NB_XI-1:0]  i_data,
    output logic [NB_ACC-1:0] o_data
);
    logic signed [NB_ACC-1:0] ext;

    assign ext    = NB_ACC'($signed(i_data));
    assign o_data = ext <<< (NBF_XO - NBF_XI);
endmodule

// File: rtl/acc_dump.sv
// acc_dump: integrate-and-dump of N_ACC aligned samples with saturated wide output
module acc_dump
    import acc_dump_pkg::*;
#(
    parameter int NB_XI  = NB_XI_D,
    parameter int NBF_XI = NBF_XI_D,
    parameter int NB_XO  = NB_XO_D,
    parameter int NBF_XO = NBF_XO_D,
    parameter int N_ACC  = N_ACC_D
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NB_XI-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_clear,
    output logic [NB_XO-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_sat
);
    localparam int NB_CNT = fx_clog2(N_ACC);
    localparam int NB_ACC = NB_XO + NB_CNT;
    localparam logic signed [NB_ACC-1:0] SAT_HI = NB_ACC'(fx_max(NB_XO));
    localparam logic signed [NB_ACC-1:0] SAT_LO = NB_ACC'(fx_min(NB_XO));

    logic [NB_CNT-1:0]        cnt;
    logic signed [NB_ACC-1:0] acc;
    logic signed [NB_ACC-1:0] aligned;
    logic signed [NB_ACC-1:0] sum;
    logic                     last;
    logic                     accept;
    logic                     hi;
    logic                     lo;
    logic [NB_XO-1:0]         sat_data;

    fx_widen #(
        .NB_XI (NB_XI),
        .NBF_XI(NBF_XI),
        .NB_ACC(NB_ACC),
        .NBF_XO(NBF_XO)
    ) u_widen (
        .i_data(i_data),
        .o_data(aligned)
    );

    // Stall only the block-completing sample while an unconsumed result occupies the output
    always_comb begin
        last     = cnt == NB_CNT'(N_ACC - 1);
        o_ready  = ~(last & o_valid & ~i_ready);
        accept   = i_valid & o_ready & ~i_clear;
        sum      = acc + aligned;
        hi       = sum > SAT_HI;
        lo       = sum < SAT_LO;
        sat_data = hi ? SAT_HI[NB_XO-1:0] : lo ? SAT_LO[NB_XO-1:0] : sum[NB_XO-1:0];
    end

    // Phase counter and running sum; clear wins over a concurrent sample
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (i_clear || (accept && last)) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            acc <= sum;
        end
    end

    // Output register: a new dump overrides a same-cycle consume, otherwise held until taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= '0;
            o_sat   <= 1'b0;
            o_valid <= 1'b0;
        end else if (accept && last) begin
            o_data  <= sat_data;
            o_sat   <= hi | lo;
            o_valid <= 1'b1;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_acc_dump.sv
// tb_acc_dump: randomized scoreboard bench for two acc_dump configurations sharing one stream
module tb_acc_dump;
    typedef struct {
        int         cyc;
        logic [16:0] d;
        logic        sat;
    } res_t;

    logic        clk;
    logic        rst;
    logic [8:0]  i_data;
    logic        i_valid;
    logic        i_clear;
    logic        i_ready;
    logic        o_ready_a, o_ready_b;
    logic [16:0] o_data_a;
    logic [11:0] o_data_b;
    logic        o_valid_a, o_valid_b;
    logic        o_sat_a, o_sat_b;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n = 0;
    int   s = 0;
    res_t sa[$];
    res_t sb[$];

    acc_dump #(.NB_XI(9), .NBF_XI(7), .NB_XO(17), .NBF_XO(10), .N_ACC(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready_a),
        .i_clear(i_clear), .o_data(o_data_a), .o_valid(o_valid_a), .i_ready(i_ready), .o_sat(o_sat_a)
    );

    acc_dump #(.NB_XI(9), .NBF_XI(7), .NB_XO(12), .NBF_XO(10), .N_ACC(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready_b),
        .i_clear(i_clear), .o_data(o_data_b), .o_valid(o_valid_b), .i_ready(i_ready), .o_sat(o_sat_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t mk(input int sum_in, input int nb);
        res_t r;
        int   v, hi, lo;
        v     = sum_in * 8;
        hi    = (1 << (nb - 1)) - 1;
        lo    = -(1 << (nb - 1));
        r.sat = (v > hi) || (v < lo);
        v     = (v > hi) ? hi : (v < lo) ? lo : v;
        r.d   = 17'(v & ((1 << nb) - 1));
        r.cyc = cyc;
        return r;
    endfunction

    task automatic step(input logic v, input logic [8:0] d, input logic r, input logic c);
        logic pend, er;
        @(posedge clk);
        #1;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_clear = c;
        #1;
        pend = sa.size() > 0;
        er   = !(n == 3 && pend && !r);
        tests++;
        if (o_ready_a !== er || o_ready_b !== er) begin
            fails++;
            $display("FAIL o_ready: got a=%b b=%b, want %b (t=%0t)", o_ready_a, o_ready_b, er, $time);
        end
        if (c) begin
            n = 0;
            s = 0;
        end else if (v && er) begin
            s += int'($signed(d));
            n++;
            if (n == 4) begin
                sa.push_back(mk(s, 17));
                sb.push_back(mk(s, 12));
                n = 0;
                s = 0;
            end
        end
    endtask

    task automatic reset_check(input string tag);
        tests++;
        if (o_valid_a !== 1'b0 || o_data_a !== 17'h0 || o_sat_a !== 1'b0 || o_ready_a !== 1'b1 ||
            o_valid_b !== 1'b0 || o_data_b !== 12'h0 || o_sat_b !== 1'b0 || o_ready_b !== 1'b1) begin
            fails++;
            $display("FAIL %s: got v=%b d=%h s=%b r=%b / v=%b d=%h s=%b r=%b, want all 0 with ready 1", tag,
                     o_valid_a, o_data_a, o_sat_a, o_ready_a, o_valid_b, o_data_b, o_sat_b, o_ready_b);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        i_valid = 0;
        i_clear = 0;
        rst     = 1;
        #1;
        reset_check(tag);
        sa.delete();
        sb.delete();
        n = 0;
        s = 0;
        @(posedge clk);
        #2;
        rst = 0;
    endtask

    // Monitor: every falling edge, compare o_valid and any presented result with the scoreboard head
    initial begin
        logic ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                ev = sa.size() > 0 && sa[0].cyc < cyc;
                tests++;
                if (o_valid_a !== ev || o_valid_b !== ev) begin
                    fails++;
                    $display("FAIL o_valid: got a=%b b=%b, want %b (t=%0t)", o_valid_a, o_valid_b, ev, $time);
                end
                if (ev) begin
                    tests++;
                    if (o_data_a !== sa[0].d || o_sat_a !== sa[0].sat) begin
                        fails++;
                        $display("FAIL data_a: got %h sat %b, want %h sat %b (t=%0t)",
                                 o_data_a, o_sat_a, sa[0].d, sa[0].sat, $time);
                    end
                    tests++;
                    if ({5'b0, o_data_b} !== sb[0].d || o_sat_b !== sb[0].sat) begin
                        fails++;
                        $display("FAIL data_b: got %h sat %b, want %h sat %b (t=%0t)",
                                 o_data_b, o_sat_b, sb[0].d[11:0], sb[0].sat, $time);
                    end
                    if (i_ready) begin
                        void'(sa.pop_front());
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_valid = 0;
        i_data  = '0;
        i_ready = 1;
        i_clear = 0;
        rst     = 0;
        #1 rst = 1;
        #2 reset_check("reset_state");
        #10 rst = 0;
        repeat (4) step(1, 9'h040, 1, 0);
        repeat (2) step(0, 9'h000, 1, 0);
        repeat (4) step(1, 9'h1C0, 1, 0);
        repeat (2) step(0, 9'h000, 1, 0);
        repeat (4) step(1, 9'h100, 1, 0);
        repeat (2) step(0, 9'h000, 1, 0);
        repeat (4) step(1, 9'h040, 1, 0);
        repeat (4) step(1, 9'h020, 0, 0);
        repeat (2) step(1, 9'h020, 0, 0);
        step(1, 9'h020, 1, 0);
        repeat (2) step(0, 9'h000, 1, 0);
        repeat (2) step(1, 9'h040, 1, 0);
        step(1, 9'h040, 1, 1);
        repeat (4) step(1, 9'h020, 1, 0);
        repeat (2) step(0, 9'h000, 1, 0);
        repeat (2) step(1, 9'h040, 1, 0);
        do_reset("reset_mid_block");
        repeat (4) step(1, 9'h040, 0, 0);
        step(0, 9'h000, 0, 0);
        do_reset("reset_pending");
        repeat (4) step(1, 9'h030, 1, 0);
        repeat (2) step(0, 9'h000, 1, 0);
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) do_reset("reset_random");
        end
        repeat (4) step(0, 9'h000, 1, 0);
        tests++;
        if (sa.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d results never delivered, want 0", sa.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
